// File: rtl/field_state_reader.sv
// Streams one record per board field: defused flag, mine flag and in-board neighbour mine count.
// Ten cycles per field (FETCH, 8x NEIGH, EMIT). EMIT holds the record until field_ready is high.
module field_state_reader #(
    parameter int MAX_SIZE = 16,
    parameter int CNT_W    = 4,
    parameter int TOT_W    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           level,
    input  logic [4:0]           button_num,
    input  logic                 start,
    input  logic [7:0][7:0]      defuse_arr_easy,
    input  logic [9:0][9:0]      defuse_arr_medium,
    input  logic [15:0][15:0]    defuse_arr_hard,
    input  logic [7:0][7:0]      mine_arr_easy,
    input  logic [9:0][9:0]      mine_arr_medium,
    input  logic [15:0][15:0]    mine_arr_hard,
    input  logic                 field_ready,
    output logic                 field_valid,
    output logic [4:0]           field_x,
    output logic [4:0]           field_y,
    output logic                 field_defused,
    output logic                 field_mine,
    output logic [CNT_W-1:0]     field_count,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic [TOT_W-1:0]     defused_total,
    output logic [TOT_W-1:0]     mines_total
);

    typedef enum logic [2:0] {IDLE, FETCH, NEIGH, EMIT, DONE} state_t;

    localparam logic [5:0] MAX_EDGE = 6'(MAX_SIZE);

    state_t            state, state_nx;
    logic [1:0]        lvl_q;
    logic [4:0]        n_q, x_q, y_q;
    logic [2:0]        nidx_q;
    logic              defused_q, mine_q;
    logic [CNT_W-1:0]  count_q;
    logic [TOT_W-1:0]  def_acc, mine_acc, def_tot, mine_tot;

    logic              start_ok, last_x, last_y, handshake;
    logic signed [5:0] dx, dy, nx, ny;
    logic              in_board, centre_def, centre_mine, neigh_mine;

    // Reads are bounded by the selected array's own edge so a board edge larger than the array reads as 0.
    function automatic logic arr_bit(input logic sel_def, input logic [1:0] lv,
                                     input logic [4:0] fx, input logic [4:0] fy);
        logic b;
        b = 1'b0;
        case (lv)
            2'd1: if (fx < 5'd8 && fy < 5'd8)
                b = sel_def ? defuse_arr_easy[fx[2:0]][fy[2:0]] : mine_arr_easy[fx[2:0]][fy[2:0]];
            2'd2: if (fx < 5'd10 && fy < 5'd10)
                b = sel_def ? defuse_arr_medium[fx[3:0]][fy[3:0]] : mine_arr_medium[fx[3:0]][fy[3:0]];
            2'd3: if (fx < 5'd16 && fy < 5'd16)
                b = sel_def ? defuse_arr_hard[fx[3:0]][fy[3:0]] : mine_arr_hard[fx[3:0]][fy[3:0]];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign start_ok  = start && (level != 2'd0) && (button_num != 5'd0) && ({1'b0, button_num} <= MAX_EDGE);
    assign last_x    = (x_q == n_q - 5'd1);
    assign last_y    = (y_q == n_q - 5'd1);
    assign handshake = (state == EMIT) && field_ready;

    always_comb begin
        dx = 6'sd0;
        dy = 6'sd0;
        case (nidx_q)
            3'd0: begin dx = -6'sd1; dy = -6'sd1; end
            3'd1: begin dx =  6'sd0; dy = -6'sd1; end
            3'd2: begin dx =  6'sd1; dy = -6'sd1; end
            3'd3: begin dx = -6'sd1; dy =  6'sd0; end
            3'd4: begin dx =  6'sd1; dy =  6'sd0; end
            3'd5: begin dx = -6'sd1; dy =  6'sd1; end
            3'd6: begin dx =  6'sd0; dy =  6'sd1; end
            default: begin dx = 6'sd1; dy = 6'sd1; end
        endcase
        nx          = $signed({1'b0, x_q}) + dx;
        ny          = $signed({1'b0, y_q}) + dy;
        in_board    = (nx >= 6'sd0) && (ny >= 6'sd0) &&
                      (nx < $signed({1'b0, n_q})) && (ny < $signed({1'b0, n_q}));
        centre_def  = arr_bit(1'b1, lvl_q, x_q, y_q);
        centre_mine = arr_bit(1'b0, lvl_q, x_q, y_q);
        neigh_mine  = in_board && arr_bit(1'b0, lvl_q, nx[4:0], ny[4:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = FETCH;
            FETCH:   state_nx = NEIGH;
            NEIGH:   if (nidx_q == 3'd7) state_nx = EMIT;
            EMIT:    if (field_ready) state_nx = (last_x && last_y) ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q     <= '0;
            n_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            nidx_q    <= '0;
            defused_q <= 1'b0;
            mine_q    <= 1'b0;
            count_q   <= '0;
            def_acc   <= '0;
            mine_acc  <= '0;
            def_tot   <= '0;
            mine_tot  <= '0;
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    lvl_q    <= level;
                    n_q      <= button_num;
                    x_q      <= '0;
                    y_q      <= '0;
                    def_acc  <= '0;
                    mine_acc <= '0;
                end
                FETCH: begin
                    defused_q <= centre_def;
                    mine_q    <= centre_mine;
                    count_q   <= '0;
                    nidx_q    <= '0;
                end
                NEIGH: begin
                    if (neigh_mine) count_q <= count_q + CNT_W'(1);
                    nidx_q <= nidx_q + 3'd1;
                end
                EMIT: if (handshake) begin
                    def_acc  <= def_acc + TOT_W'(defused_q);
                    mine_acc <= mine_acc + TOT_W'(mine_q);
                    if (last_x && last_y) begin
                        // Totals include the final record so they are valid during the DONE pulse.
                        def_tot  <= def_acc + TOT_W'(defused_q);
                        mine_tot <= mine_acc + TOT_W'(mine_q);
                    end else if (last_x) begin
                        x_q <= '0;
                        y_q <= y_q + 5'd1;
                    end else begin
                        x_q <= x_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign field_valid   = (state == EMIT);
    assign scan_busy     = (state == FETCH) || (state == NEIGH) || (state == EMIT);
    assign scan_done     = (state == DONE);
    assign field_x       = x_q;
    assign field_y       = y_q;
    assign field_defused = defused_q;
    assign field_mine    = mine_q;
    assign field_count   = count_q;
    assign defused_total = def_tot;
    assign mines_total   = mine_tot;

endmodule

// File: tb/tb_field_state_reader.sv
// Bench for field_state_reader: board model, expected-record queue, and a monitor comparing on handshakes.
module tb_field_state_reader;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          level;
    logic [4:0]          button_num;
    logic                start;
    logic [7:0][7:0]     de_e, mi_e;
    logic [9:0][9:0]     de_m, mi_m;
    logic [15:0][15:0]   de_h, mi_h;
    logic                field_ready;
    logic                field_valid, field_defused, field_mine, scan_busy, scan_done;
    logic [4:0]          field_x, field_y;
    logic [3:0]          field_count;
    logic [8:0]          defused_total, mines_total;

    field_state_reader dut (
        .clk(clk), .rst(rst), .level(level), .button_num(button_num), .start(start),
        .defuse_arr_easy(de_e), .defuse_arr_medium(de_m), .defuse_arr_hard(de_h),
        .mine_arr_easy(mi_e), .mine_arr_medium(mi_m), .mine_arr_hard(mi_h),
        .field_ready(field_ready), .field_valid(field_valid), .field_x(field_x), .field_y(field_y),
        .field_defused(field_defused), .field_mine(field_mine), .field_count(field_count),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .defused_total(defused_total), .mines_total(mines_total)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int d; int m; int c; } rec_t;
    typedef struct { int d; int m; } tot_t;

    rec_t exp_q[$];
    tot_t tot_q[$];
    int   nchk = 0, nerr = 0;
    int   cyc = 0, last_hs = 0;
    int   ready_mode = 0;     // 0: always ready, 1: random, 2: driven by the main sequence
    bit   gap_en = 0;
    bit   hold_vld = 0;
    rec_t snap;

    task automatic check(input string name, input int act, input int expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Board model: what the field holds at (x,y) on a given level; anything outside the array reads 0.
    function automatic int get_bit(input int lv, input bit is_def, input int x, input int y);
        if (x < 0 || y < 0) return 0;
        case (lv)
            1: if (x < 8 && y < 8)   return is_def ? int'(de_e[x[2:0]][y[2:0]]) : int'(mi_e[x[2:0]][y[2:0]]);
            2: if (x < 10 && y < 10) return is_def ? int'(de_m[x[3:0]][y[3:0]]) : int'(mi_m[x[3:0]][y[3:0]]);
            3: if (x < 16 && y < 16) return is_def ? int'(de_h[x[3:0]][y[3:0]]) : int'(mi_h[x[3:0]][y[3:0]]);
            default: return 0;
        endcase
        return 0;
    endfunction

    task automatic push_scan(input int lv, input int n);
        tot_t t;
        t.d = 0;
        t.m = 0;
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++) begin
                rec_t r;
                r.x = x; r.y = y;
                r.d = get_bit(lv, 1'b1, x, y);
                r.m = get_bit(lv, 1'b0, x, y);
                r.c = 0;
                for (int j = -1; j <= 1; j++)
                    for (int i = -1; i <= 1; i++)
                        if (!(i == 0 && j == 0) && x + i >= 0 && x + i < n && y + j >= 0 && y + j < n)
                            r.c += get_bit(lv, 1'b0, x + i, y + j);
                t.d += r.d;
                t.m += r.m;
                exp_q.push_back(r);
            end
        tot_q.push_back(t);
    endtask

    task automatic randomize_boards();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                de_h[x][y] = 1'($urandom_range(0, 1));
                mi_h[x][y] = 1'($urandom_range(0, 3) == 0);
                if (x < 10 && y < 10) begin
                    de_m[x][y] = 1'($urandom_range(0, 1));
                    mi_m[x][y] = 1'($urandom_range(0, 3) == 0);
                end
                if (x < 8 && y < 8) begin
                    de_e[x][y] = 1'($urandom_range(0, 1));
                    mi_e[x][y] = 1'($urandom_range(0, 3) == 0);
                end
            end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      field_ready = 1'b1;
        else if (ready_mode == 1) field_ready = 1'($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every accepted record and every scan_done against the expected queues.
    always @(negedge clk) begin
        if (!rst) begin
            hold_vld = 0;
        end else begin
            if (field_valid) begin
                if (hold_vld) begin
                    check("stall_x", int'(field_x), snap.x);
                    check("stall_y", int'(field_y), snap.y);
                    check("stall_def", int'(field_defused), snap.d);
                    check("stall_mine", int'(field_mine), snap.m);
                    check("stall_cnt", int'(field_count), snap.c);
                end
                if (field_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_record", 1, 0);
                    end else begin
                        rec_t e;
                        e = exp_q.pop_front();
                        check("rec_x", int'(field_x), e.x);
                        check("rec_y", int'(field_y), e.y);
                        check("rec_defused", int'(field_defused), e.d);
                        check("rec_mine", int'(field_mine), e.m);
                        check("rec_count", int'(field_count), e.c);
                        if (gap_en && !(e.x == 0 && e.y == 0))
                            check("record_period", cyc - last_hs, 10);
                    end
                    last_hs  = cyc;
                    hold_vld = 0;
                end else begin
                    snap.x = int'(field_x); snap.y = int'(field_y);
                    snap.d = int'(field_defused); snap.m = int'(field_mine); snap.c = int'(field_count);
                    hold_vld = 1;
                end
            end else begin
                hold_vld = 0;
            end
            if (scan_done) begin
                check("done_after_last_accept", cyc - last_hs, 1);
                check("done_busy_low", int'(scan_busy), 0);
                if (tot_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    tot_t t;
                    t = tot_q.pop_front();
                    check("defused_total", int'(defused_total), t.d);
                    check("mines_total", int'(mines_total), t.m);
                end
            end
        end
    end

    // Pulse start; the FSM is in FETCH after the accepting edge, so EMIT (cycle N+10) is 9 edges later.
    task automatic do_start(input int lv, input int n);
        int k;
        level = 2'(lv);
        button_num = 5'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!field_valid && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("first_valid_latency", k, 9);
    endtask

    task automatic wait_done(input bit poke_start);
        int k;
        k = 0;
        while (!scan_done && k < 8000) begin
            @(posedge clk); #1;
            k++;
        end
        check("scan_done_seen", int'(scan_done), 1);
        if (poke_start) start = 1'b1;
        @(negedge clk); #1;
        check("records_left", exp_q.size(), 0);
        check("totals_left", tot_q.size(), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_after_done", int'(scan_busy), 0);
    endtask

    task automatic bad_start(input int lv, input int n);
        int seen;
        level = 2'(lv);
        button_num = 5'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        repeat (12) begin
            seen |= int'(scan_busy) | int'(field_valid);
            @(posedge clk); #1;
        end
        check($sformatf("rejected_start_l%0d_n%0d", lv, n), seen, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; level = '0; button_num = '0; field_ready = 1'b1;
        de_e = '0; mi_e = '0; de_m = '0; mi_m = '0; de_h = '0; mi_h = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(field_valid), 0);
        check("reset_busy", int'(scan_busy), 0);
        check("reset_done", int'(scan_done), 0);
        check("reset_xy", int'(field_x) + int'(field_y), 0);
        check("reset_totals", int'(defused_total) + int'(mines_total), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Easy board, single mine in the corner, strict 10-cycle cadence; start in DONE must be ignored.
        mi_e[0][0] = 1'b1;
        gap_en = 1;
        push_scan(1, 8);
        do_start(1, 8);
        wait_done(1'b1);
        gap_en = 0;

        // Hard board full of mines under random backpressure.
        randomize_boards();
        mi_h = '1;
        ready_mode = 1;
        push_scan(3, 16);
        do_start(3, 16);
        wait_done(1'b0);

        // Rejected starts.
        ready_mode = 0;
        bad_start(0, 8);
        bad_start(1, 17);

        // Five-cycle stall at record (2,0).
        randomize_boards();
        ready_mode = 2;
        field_ready = 1'b1;
        push_scan(1, 8);
        do_start(1, 8);
        begin
            int k;
            k = 0;
            while (!(field_valid && field_x == 5'd2 && field_y == 5'd0) && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            check("reach_stall_point", k < 100 ? 1 : 0, 1);
        end
        field_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("valid_held_in_stall", int'(field_valid), 1);
        field_ready = 1'b1;
        wait_done(1'b0);
        ready_mode = 0;

        // Medium board, defused row y=3; level and start poked mid-scan must not disturb the scan.
        randomize_boards();
        de_m = '0;
        for (int x = 0; x < 10; x++) de_m[x][3] = 1'b1;
        ready_mode = 1;
        push_scan(2, 10);
        do_start(2, 10);
        repeat (25) @(posedge clk);
        #1;
        level = 2'd3;
        button_num = 5'd16;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0);
        ready_mode = 0;

        // Asynchronous reset in NEIGH of (4,2), then a fresh scan from (0,0).
        randomize_boards();
        push_scan(1, 8);
        do_start(1, 8);
        begin
            int k;
            k = 0;
            while (!(field_valid && field_x == 5'd3 && field_y == 5'd2) && k < 400) begin
                @(posedge clk); #1;
                k++;
            end
            check("reach_reset_point", k < 400 ? 1 : 0, 1);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", int'(field_valid), 0);
        check("arst_busy", int'(scan_busy), 0);
        check("arst_xy", int'(field_x) + int'(field_y), 0);
        check("arst_record", int'(field_defused) + int'(field_mine) + int'(field_count), 0);
        check("arst_totals", int'(defused_total) + int'(mines_total), 0);
        exp_q.delete();
        tot_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        push_scan(1, 8);
        do_start(1, 8);
        wait_done(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
